// File: rtl/spi_frame_pkg.sv
// Definitions shared by the frame sequencer and the SPI frame reader:
// read opcode, frame geometry, sequencer states and frame address helper.
package spi_frame_pkg;

  localparam logic [7:0] CMD_READ    = 8'h03;
  localparam int         DATA_SIZE   = 8192;
  localparam int         FRAME_BYTES = DATA_SIZE / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } seq_state_e;

  // Byte address of a frame in flash; index 255 still fits in 24 bits.
  function automatic logic [23:0] frame_addr(input logic [7:0] index);
    return {16'b0, index} << $clog2(FRAME_BYTES);
  endfunction

endpackage

// File: rtl/period_timer.sv
// Free-running period counter: counts 0..PERIOD-1, wraps, and flags the
// last count with tick.
module period_timer #(
  parameter int PERIOD = 33554432
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Walks the active layer list once per period, issuing one flash load
// request per layer: layer 0 overwrites the frame buffer, later layers OR in.
//
// state | meaning
// IDLE  | waiting for a period tick with enable and a non-zero layer count
// ISSUE | rd_req held for the current layer until the reader acks
// WAIT  | reader shifting the frame; rd_done ends the layer
// DONE  | one-cycle frame_done pulse, then back to IDLE
module frame_sequencer #(
  parameter int NUM_LAYERS  = 3,
  parameter int FRAME_BYTES = 1024,
  parameter int PERIOD      = 33554432
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] frames,
  input  logic [2:0]  layer_count,
  output logic        rd_req,
  output logic [23:0] rd_addr,
  output logic        rd_merge,
  input  logic        rd_ack,
  input  logic        rd_done,
  output logic        busy,
  output logic [1:0]  layer,
  output logic        frame_done,
  output logic        overrun
);

  import spi_frame_pkg::*;

  localparam int         ADDR_SHIFT = $clog2(FRAME_BYTES);
  localparam logic [2:0] MAX_LAYERS = 3'(NUM_LAYERS);

  function automatic logic [23:0] addr_of(input logic [7:0] idx);
    return {16'b0, idx} << ADDR_SHIFT;
  endfunction

  seq_state_e  state_q;
  logic [31:0] frames_q;
  logic [2:0]  count_q;
  logic [1:0]  layer_q;
  logic        rd_req_q;
  logic [23:0] rd_addr_q;
  logic        rd_merge_q;
  logic        frame_done_q;
  logic        overrun_q;

  logic       tick;
  logic [2:0] count_d;
  logic [1:0] layer_d;
  logic       last_layer;

  period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    count_d    = (layer_count > MAX_LAYERS) ? MAX_LAYERS : layer_count;
    layer_d    = layer_q + 2'd1;
    last_layer = ({1'b0, layer_q} == (count_q - 3'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      frames_q     <= '0;
      count_q      <= '0;
      layer_q      <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      rd_merge_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // A tick that lands on any non-idle state, DONE included, is dropped.
      overrun_q <= tick && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (tick && enable && (count_d != 3'd0)) begin
            frames_q   <= frames;
            count_q    <= count_d;
            layer_q    <= 2'd0;
            rd_req_q   <= 1'b1;
            rd_addr_q  <= addr_of(frames[7:0]);
            rd_merge_q <= 1'b0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (rd_ack) begin
            rd_req_q <= 1'b0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (rd_done) begin
            if (last_layer) begin
              frame_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              layer_q    <= layer_d;
              rd_req_q   <= 1'b1;
              rd_addr_q  <= addr_of(frames_q[{layer_d, 3'b000} +: 8]);
              rd_merge_q <= 1'b1;
              state_q    <= ISSUE;
            end
          end
        end
        DONE: begin
          frame_done_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign rd_merge   = rd_merge_q;
  assign busy       = (state_q != IDLE);
  assign layer      = layer_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with a behavioural SPI reader whose
// ack and done latencies are adjustable per scenario.
module tb_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] frames;
  logic [2:0]  layer_count;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_merge;
  logic        rd_ack;
  logic        rd_done;
  logic        busy;
  logic [1:0]  layer;
  logic        frame_done;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  int ack_dly  = 0;
  int done_dly = 10;

  int cyc      = 0;
  int fd_cnt   = 0;
  int ov_cnt   = 0;
  int rise_cnt = 0;
  int fd_last  = 0;
  int fd_prev  = 0;
  logic [23:0] log_addr[$];
  logic        log_merge[$];
  logic [1:0]  log_layer[$];

  frame_sequencer #(
    .NUM_LAYERS  (3),
    .FRAME_BYTES (1024),
    .PERIOD      (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .frames      (frames),
    .layer_count (layer_count),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_merge    (rd_merge),
    .rd_ack      (rd_ack),
    .rd_done     (rd_done),
    .busy        (busy),
    .layer       (layer),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Reader model and event monitor, both acting on the falling edge.
  initial begin : reader
    int   phase;
    int   cnt;
    logic prev_req;
    phase    = 0;
    cnt      = 0;
    prev_req = 1'b0;
    rd_ack   = 1'b0;
    rd_done  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      rd_ack  = 1'b0;
      rd_done = 1'b0;
      if (frame_done === 1'b1) begin
        fd_cnt++;
        fd_prev = fd_last;
        fd_last = cyc;
      end
      if (overrun === 1'b1) ov_cnt++;
      if (rd_req === 1'b1 && prev_req !== 1'b1) rise_cnt++;
      prev_req = rd_req;
      if (rst === 1'b1) begin
        phase = 0;
      end else begin
        case (phase)
          0: if (rd_req === 1'b1) begin
            log_addr.push_back(rd_addr);
            log_merge.push_back(rd_merge);
            log_layer.push_back(layer);
            if (ack_dly == 0) begin
              rd_ack = 1'b1;
              cnt    = done_dly;
              phase  = 2;
            end else begin
              cnt   = ack_dly;
              phase = 1;
            end
          end
          1: begin
            cnt--;
            if (cnt == 0) begin
              rd_ack = 1'b1;
              cnt    = done_dly;
              phase  = 2;
            end
          end
          default: begin
            cnt--;
            if (cnt == 0) begin
              rd_done = 1'b1;
              phase   = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic wait_fd(input int n, input int budget, input string name);
    int fd0 = fd_cnt;
    for (int i = 0; i < budget && (fd_cnt - fd0) < n; i++) @(negedge clk);
    total++;
    if (fd_cnt - fd0 < n) begin
      bad++;
      $display("FAIL %s timeout: frame_done seen %0d, wanted %0d", name, fd_cnt - fd0, n);
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    for (int i = 0; i < budget && log_addr.size() < n; i++) @(negedge clk);
    total++;
    if (log_addr.size() < n) begin
      bad++;
      $display("FAIL %s timeout: requests logged %0d, wanted %0d", name, log_addr.size(), n);
    end
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    enable      = 1'b1;
    frames      = 32'hF00F5511;
    layer_count = 3'd3;
    repeat (3) @(negedge clk);
    total += 7;
    if (rd_req !== 1'b0)     begin bad++; $display("FAIL reset_rd_req got %b want 0", rd_req); end
    if (rd_addr !== 24'h0)   begin bad++; $display("FAIL reset_rd_addr got %h want 0", rd_addr); end
    if (rd_merge !== 1'b0)   begin bad++; $display("FAIL reset_rd_merge got %b want 0", rd_merge); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (layer !== 2'd0)      begin bad++; $display("FAIL reset_layer got %0d want 0", layer); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    if (overrun !== 1'b0)    begin bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [23:0] exp_addr [3] = '{24'h04400, 24'h15400, 24'h03C00};
    int l0 = log_addr.size();
    wait_fd(2, 300, "basic");
    total++;
    if (log_addr.size() - l0 != 6) begin
      bad++; $display("FAIL basic_req_count got %0d want 6", log_addr.size() - l0);
    end
    for (int j = 0; j < 6 && l0 + j < log_addr.size(); j++) begin
      total += 3;
      if (log_addr[l0+j] !== exp_addr[j%3]) begin
        bad++; $display("FAIL basic_addr[%0d] got %h want %h", j, log_addr[l0+j], exp_addr[j%3]);
      end
      if (log_merge[l0+j] !== ((j % 3) != 0)) begin
        bad++; $display("FAIL basic_merge[%0d] got %b want %b", j, log_merge[l0+j], (j % 3) != 0);
      end
      if (log_layer[l0+j] !== 2'(j % 3)) begin
        bad++; $display("FAIL basic_layer[%0d] got %0d want %0d", j, log_layer[l0+j], j % 3);
      end
    end
    total++;
    if (fd_last - fd_prev != 64) begin
      bad++; $display("FAIL basic_done_spacing got %0d want 64", fd_last - fd_prev);
    end
  endtask

  task automatic test_layer_count;
    int r0  = rise_cnt;
    int fd0 = fd_cnt;
    int l0;
    layer_count = 3'd0;
    repeat (192) @(negedge clk);
    total += 3;
    if (rise_cnt != r0) begin bad++; $display("FAIL count0_requests got %0d want 0", rise_cnt - r0); end
    if (fd_cnt != fd0)  begin bad++; $display("FAIL count0_frame_done got %0d want 0", fd_cnt - fd0); end
    if (busy !== 1'b0)  begin bad++; $display("FAIL count0_busy got %b want 0", busy); end
    layer_count = 3'd7;
    l0 = log_addr.size();
    wait_fd(3, 300, "count7");
    total++;
    if (log_addr.size() - l0 != 9) begin
      bad++; $display("FAIL count7_requests got %0d want 9", log_addr.size() - l0);
    end
    if (log_addr.size() >= l0 + 9) begin
      total += 2;
      if (log_layer[l0+8] !== 2'd2) begin
        bad++; $display("FAIL count7_last_layer got %0d want 2", log_layer[l0+8]);
      end
      if (log_addr[l0+8] !== 24'h03C00) begin
        bad++; $display("FAIL count7_last_addr got %h want 03c00", log_addr[l0+8]);
      end
    end
  endtask

  task automatic test_overrun;
    int ov0 = ov_cnt;
    int r0  = rise_cnt;
    int l0  = log_addr.size();
    layer_count = 3'd1;
    done_dly    = 100;
    wait_fd(1, 300, "overrun");
    total += 3;
    if (ov_cnt - ov0 != 1)  begin bad++; $display("FAIL overrun_pulses got %0d want 1", ov_cnt - ov0); end
    if (rise_cnt - r0 != 1) begin bad++; $display("FAIL overrun_requests got %0d want 1", rise_cnt - r0); end
    if (log_addr.size() > l0 && log_addr[l0] !== 24'h04400) begin
      bad++; $display("FAIL overrun_addr got %h want 04400", log_addr[l0]);
    end
    done_dly = 10;
  endtask

  task automatic test_snapshot;
    int l0 = log_addr.size();
    layer_count = 3'd3;
    wait_log(l0 + 2, 200, "snap_layer1");
    if (log_addr.size() >= l0 + 2) begin
      total++;
      if (log_layer[l0+1] !== 2'd1) begin bad++; $display("FAIL snap_layer1 got %0d want 1", log_layer[l0+1]); end
    end
    repeat (2) @(negedge clk);
    frames = 32'h00000001;
    wait_log(l0 + 3, 50, "snap_layer2");
    if (log_addr.size() >= l0 + 3) begin
      total += 2;
      if (log_addr[l0+2] !== 24'h03C00) begin bad++; $display("FAIL snap_old_addr got %h want 03c00", log_addr[l0+2]); end
      if (log_merge[l0+2] !== 1'b1)     begin bad++; $display("FAIL snap_old_merge got %b want 1", log_merge[l0+2]); end
    end
    wait_log(l0 + 5, 200, "snap_next");
    if (log_addr.size() >= l0 + 5) begin
      total += 4;
      if (log_addr[l0+3] !== 24'h00400) begin bad++; $display("FAIL snap_new_addr0 got %h want 00400", log_addr[l0+3]); end
      if (log_merge[l0+3] !== 1'b0)     begin bad++; $display("FAIL snap_new_merge0 got %b want 0", log_merge[l0+3]); end
      if (log_addr[l0+4] !== 24'h00000) begin bad++; $display("FAIL snap_new_addr1 got %h want 00000", log_addr[l0+4]); end
      if (log_merge[l0+4] !== 1'b1)     begin bad++; $display("FAIL snap_new_merge1 got %b want 1", log_merge[l0+4]); end
    end
  endtask

  task automatic test_ack_delay;
    int seen = 0;
    wait_fd(1, 100, "ackdly_idle");
    frames      = 32'hF00F5511;
    layer_count = 3'd1;
    ack_dly     = 5;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (rd_req === 1'b1) seen = 1;
    end
    total++;
    if (seen == 0) begin
      bad++; $display("FAIL ackdly_req timeout: rd_req got %b want 1", rd_req);
    end else begin
      for (int k = 0; k <= 5; k++) begin
        total += 2;
        if (rd_req !== 1'b1)       begin bad++; $display("FAIL ackdly_hold_req[%0d] got %b want 1", k, rd_req); end
        if (rd_addr !== 24'h04400) begin bad++; $display("FAIL ackdly_hold_addr[%0d] got %h want 04400", k, rd_addr); end
        if (k < 5) @(negedge clk);
      end
      @(negedge clk);
      total += 2;
      if (rd_req !== 1'b0) begin bad++; $display("FAIL ackdly_fall got %b want 0", rd_req); end
      if (busy !== 1'b1)   begin bad++; $display("FAIL ackdly_busy got %b want 1", busy); end
    end
    ack_dly = 0;
    wait_fd(1, 50, "ackdly_done");
  endtask

  task automatic test_reset_mid;
    int l0    = log_addr.size();
    int early = 0;
    layer_count = 3'd3;
    wait_log(l0 + 2, 200, "rstmid_layer1");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total += 7;
    if (rd_req !== 1'b0)     begin bad++; $display("FAIL rstmid_rd_req got %b want 0", rd_req); end
    if (rd_addr !== 24'h0)   begin bad++; $display("FAIL rstmid_rd_addr got %h want 0", rd_addr); end
    if (rd_merge !== 1'b0)   begin bad++; $display("FAIL rstmid_rd_merge got %b want 0", rd_merge); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (layer !== 2'd0)      begin bad++; $display("FAIL rstmid_layer got %0d want 0", layer); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL rstmid_frame_done got %b want 0", frame_done); end
    if (overrun !== 1'b0)    begin bad++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
    rst = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      @(negedge clk);
      if (rd_req !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL rstmid_early_req got %0d cycles want 0", early); end
    @(negedge clk);
    total += 3;
    if (rd_req !== 1'b1)       begin bad++; $display("FAIL rstmid_restart_req got %b want 1", rd_req); end
    if (rd_addr !== 24'h04400) begin bad++; $display("FAIL rstmid_restart_addr got %h want 04400", rd_addr); end
    if (rd_merge !== 1'b0)     begin bad++; $display("FAIL rstmid_restart_merge got %b want 0", rd_merge); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_layer_count();
    test_overrun();
    test_snapshot();
    test_ack_delay();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
